// File: rtl/seq2_fetch.sv
// Instruction-fetch stage feeding the Seq2 sequencer from a local program memory.
// Optional breakpoint stop is compiled in with the SEQ2_FETCH_BREAK_EN macro.
module seq2_fetch #(
    parameter int ADDR_WIDTH = 8,
    parameter int INST_WIDTH = 20
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_wen,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [INST_WIDTH-1:0] load_data,
    input  logic                  start,
    input  logic                  stop,
    input  logic [ADDR_WIDTH-1:0] next,
    input  logic [ADDR_WIDTH-1:0] brk_addr,
    input  logic                  brk_valid,
    output logic [INST_WIDTH-1:0] inst,
    output logic                  inst_en,
    output logic                  running,
    output logic                  load_err,
    output logic [15:0]           fetch_count,
    output logic                  brk_hit
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic do_fetch;
    logic mem_we;
    logic set_err;
    logic accept_start;
    logic brk_stop;
    logic brk_match;

    logic [INST_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

`ifdef SEQ2_FETCH_BREAK_EN
    assign brk_match = brk_valid && (next == brk_addr);
`else
    logic unused_brk;
    assign brk_match  = 1'b0;
    assign unused_brk = ^{brk_addr, brk_valid};
`endif

    // A breakpoint takes priority over stop so brk_hit is reported even when both occur.
    always_comb begin
        state_next   = state;
        do_fetch     = 1'b0;
        mem_we       = 1'b0;
        set_err      = 1'b0;
        accept_start = 1'b0;
        brk_stop     = 1'b0;
        case (state)
            IDLE: begin
                mem_we = load_wen;
                if (start && !stop) begin
                    state_next   = RUN;
                    accept_start = 1'b1;
                end
            end
            RUN: begin
                set_err = load_wen;
                if (brk_match) begin
                    state_next = IDLE;
                    brk_stop   = 1'b1;
                end else if (stop) begin
                    state_next = IDLE;
                end else begin
                    do_fetch = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Program memory has no reset so the loaded program survives a reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            running     <= 1'b0;
            inst        <= '0;
            inst_en     <= 1'b0;
            load_err    <= 1'b0;
            fetch_count <= 16'h0000;
        end else begin
            state   <= state_next;
            running <= (state_next == RUN);
            inst_en <= do_fetch;
            if (do_fetch) begin
                inst <= mem[next];
            end
            if (accept_start) begin
                load_err <= 1'b0;
            end else if (set_err) begin
                load_err <= 1'b1;
            end
            // Counts edges on which the already-registered inst_en is high; saturates.
            if (accept_start) begin
                fetch_count <= 16'h0000;
            end else if (inst_en && (fetch_count != 16'hFFFF)) begin
                fetch_count <= fetch_count + 16'h0001;
            end
        end
    end

`ifdef SEQ2_FETCH_BREAK_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            brk_hit <= 1'b0;
        end else begin
            brk_hit <= brk_stop;
        end
    end
`else
    logic unused_brk_stop;
    assign unused_brk_stop = brk_stop;
    assign brk_hit         = 1'b0;
`endif

endmodule

// File: tb/tb_seq2_fetch.sv
// Directed self-checking bench for seq2_fetch; breakpoint steps run when
// SEQ2_FETCH_BREAK_EN is defined.
module tb_seq2_fetch;

    logic        clock;
    logic        reset;
    logic        load_wen;
    logic [7:0]  load_addr;
    logic [19:0] load_data;
    logic        start;
    logic        stop;
    logic [7:0]  next;
    logic [7:0]  brk_addr;
    logic        brk_valid;
    logic [19:0] inst;
    logic        inst_en;
    logic        running;
    logic        load_err;
    logic [15:0] fetch_count;
    logic        brk_hit;

    int total;
    int bad;

    seq2_fetch #(
        .ADDR_WIDTH(8),
        .INST_WIDTH(20)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .load_wen   (load_wen),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .start      (start),
        .stop       (stop),
        .next       (next),
        .brk_addr   (brk_addr),
        .brk_valid  (brk_valid),
        .inst       (inst),
        .inst_en    (inst_en),
        .running    (running),
        .load_err   (load_err),
        .fetch_count(fetch_count),
        .brk_hit    (brk_hit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance n rising edges, leaving time 1ns past the last edge.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic loadWord(input logic [7:0] a, input logic [19:0] d);
        load_wen  = 1'b1;
        load_addr = a;
        load_data = d;
        applyStimulus(1);
        load_wen  = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        load_wen  = 1'b0;
        load_addr = 8'h00;
        load_data = 20'h0;
        start     = 1'b0;
        stop      = 1'b0;
        next      = 8'h00;
        brk_addr  = 8'h00;
        brk_valid = 1'b0;
        #3;
        checkOutput("rst_inst", {12'h0, inst}, 32'h0);
        checkOutput("rst_inst_en", {31'h0, inst_en}, 32'h0);
        checkOutput("rst_running", {31'h0, running}, 32'h0);
        checkOutput("rst_load_err", {31'h0, load_err}, 32'h0);
        checkOutput("rst_fetch_count", {16'h0, fetch_count}, 32'h0);
        checkOutput("rst_brk_hit", {31'h0, brk_hit}, 32'h0);
        applyStimulus(1);
        reset = 1'b0;

        // Test 1: load program and fetch with one-cycle latency
        loadWord(8'h00, 20'h1_2AAA);
        loadWord(8'h01, 20'h0_0000);
        loadWord(8'h02, 20'h3_A000);
        loadWord(8'hFF, 20'h5_5555);
        loadWord(8'h9F, 20'h6_0001);
        loadWord(8'hA0, 20'h7_1234);
        checkOutput("idle_inst_en", {31'h0, inst_en}, 32'h0);
        start = 1'b1;
        next  = 8'h00;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("t1_running", {31'h0, running}, 32'h1);
        checkOutput("t1_first_edge_en", {31'h0, inst_en}, 32'h0);
        applyStimulus(1);
        checkOutput("t1_inst0_en", {31'h0, inst_en}, 32'h1);
        checkOutput("t1_inst0", {12'h0, inst}, 32'h1_2AAA);
        checkOutput("t1_fc0", {16'h0, fetch_count}, 32'h0);
        next = 8'h02;
        applyStimulus(1);
        checkOutput("t1_inst2", {12'h0, inst}, 32'h3_A000);
        checkOutput("t1_fc1", {16'h0, fetch_count}, 32'h1);

        // Test 2: held address re-presented each cycle
        next = 8'h01;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1);
            checkOutput("t2_hold_inst", {12'h0, inst}, 32'h0);
            checkOutput("t2_hold_en", {31'h0, inst_en}, 32'h1);
            checkOutput("t2_hold_fc", {16'h0, fetch_count}, 32'(2 + i));
        end

        // Address wrap FF -> 00
        next = 8'hFF;
        applyStimulus(1);
        checkOutput("wrap_ff", {12'h0, inst}, 32'h5_5555);
        next = 8'h00;
        applyStimulus(1);
        checkOutput("wrap_00", {12'h0, inst}, 32'h1_2AAA);
        checkOutput("wrap_fc", {16'h0, fetch_count}, 32'd8);

        // Test 3: load during RUN is rejected and flagged
        next      = 8'h01;
        load_wen  = 1'b1;
        load_addr = 8'h00;
        load_data = 20'hF_FFEE;
        applyStimulus(1);
        load_wen = 1'b0;
        checkOutput("t3_load_err", {31'h0, load_err}, 32'h1);
        checkOutput("t3_inst", {12'h0, inst}, 32'h0);
        stop = 1'b1;
        applyStimulus(1);
        stop = 1'b0;
        checkOutput("t3_stop_running", {31'h0, running}, 32'h0);
        checkOutput("t3_stop_en", {31'h0, inst_en}, 32'h0);
        checkOutput("t3_stop_fc", {16'h0, fetch_count}, 32'd10);
        applyStimulus(1);
        checkOutput("t3_err_sticky", {31'h0, load_err}, 32'h1);
        checkOutput("t3_idle_fc_hold", {16'h0, fetch_count}, 32'd10);
        start = 1'b1;
        next  = 8'h00;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("t3_restart_err_clr", {31'h0, load_err}, 32'h0);
        checkOutput("t3_restart_fc_clr", {16'h0, fetch_count}, 32'h0);
        applyStimulus(1);
        checkOutput("t3_mem0_intact", {12'h0, inst}, 32'h1_2AAA);

        // Test 4: stop in RUN holds inst; start+stop in IDLE stays IDLE
        next = 8'h02;
        stop = 1'b1;
        applyStimulus(1);
        stop = 1'b0;
        checkOutput("t4_stop_en", {31'h0, inst_en}, 32'h0);
        checkOutput("t4_stop_inst_hold", {12'h0, inst}, 32'h1_2AAA);
        start = 1'b1;
        stop  = 1'b1;
        applyStimulus(2);
        start = 1'b0;
        stop  = 1'b0;
        checkOutput("t4_both_running", {31'h0, running}, 32'h0);
        checkOutput("t4_both_en", {31'h0, inst_en}, 32'h0);

        // Test 5: asynchronous reset mid-RUN
        start = 1'b1;
        next  = 8'h02;
        applyStimulus(1);
        start = 1'b0;
        applyStimulus(2);
        checkOutput("t5_pre_inst", {12'h0, inst}, 32'h3_A000);
        checkOutput("t5_pre_fc", {16'h0, fetch_count}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t5_rst_en", {31'h0, inst_en}, 32'h0);
        checkOutput("t5_rst_running", {31'h0, running}, 32'h0);
        checkOutput("t5_rst_fc", {16'h0, fetch_count}, 32'h0);
        #2;
        reset = 1'b0;
        start = 1'b1;
        next  = 8'h00;
        applyStimulus(1);
        start = 1'b0;
        applyStimulus(1);
        checkOutput("t5_mem0_after_rst", {12'h0, inst}, 32'h1_2AAA);

        // fetch_count saturation
        applyStimulus(65534);
        checkOutput("sat_fffe", {16'h0, fetch_count}, 32'hFFFE);
        applyStimulus(1);
        checkOutput("sat_ffff", {16'h0, fetch_count}, 32'hFFFF);
        applyStimulus(3);
        checkOutput("sat_hold", {16'h0, fetch_count}, 32'hFFFF);
        stop = 1'b1;
        applyStimulus(1);
        stop = 1'b0;
        checkOutput("sat_stop", {31'h0, running}, 32'h0);

`ifdef SEQ2_FETCH_BREAK_EN
        // Test 6: breakpoint stop and resume past it
        start = 1'b1;
        next  = 8'h9F;
        applyStimulus(1);
        start     = 1'b0;
        brk_addr  = 8'hA0;
        brk_valid = 1'b1;
        applyStimulus(1);
        checkOutput("t6_pre_inst", {12'h0, inst}, 32'h6_0001);
        next = 8'hA0;
        applyStimulus(1);
        checkOutput("t6_brk_hit", {31'h0, brk_hit}, 32'h1);
        checkOutput("t6_brk_en", {31'h0, inst_en}, 32'h0);
        checkOutput("t6_brk_running", {31'h0, running}, 32'h0);
        checkOutput("t6_brk_inst_hold", {12'h0, inst}, 32'h6_0001);
        applyStimulus(1);
        checkOutput("t6_brk_pulse_end", {31'h0, brk_hit}, 32'h0);
        brk_valid = 1'b0;
        start     = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        applyStimulus(1);
        checkOutput("t6_resume_inst", {12'h0, inst}, 32'h7_1234);
        checkOutput("t6_resume_en", {31'h0, inst_en}, 32'h1);
`else
        // Breakpoint inputs must have no effect without the feature
        start     = 1'b1;
        next      = 8'h9F;
        brk_addr  = 8'hA0;
        brk_valid = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        next  = 8'hA0;
        applyStimulus(2);
        checkOutput("nobrk_hit", {31'h0, brk_hit}, 32'h0);
        checkOutput("nobrk_running", {31'h0, running}, 32'h1);
        checkOutput("nobrk_inst", {12'h0, inst}, 32'h7_1234);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
